// File: rtl/rng_draw.sv
// rng_draw: pseudo-random draw unit for game logic.
//
// A free-running Galois LFSR is stepped every cycle. Any change on the player
// input bus I is XORed into the next LFSR value, so I also acts as an entropy
// source. A request draws one value in [0, RANGE-1] by rejection sampling on
// the low OUT_W LFSR bits. After MAX_TRIES rejected candidates it falls back
// to cand - RANGE.
//
// Optional build macro RNG_SEED_LOAD_EN adds the Load/SeedIn ports, which
// overwrite the LFSR directly.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for Req; Busy low
// DRAW  | testing one candidate per cycle against RANGE
// DONE  | Value/Valid held stable until Ack

module rng_draw #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED      = 16'hACE1,
  parameter int unsigned       IN_W      = 2,
  parameter int unsigned       RANGE     = 3,
  parameter int unsigned       MAX_TRIES = 4,
  localparam int unsigned      OUT_W     = (RANGE <= 2) ? 1 : $clog2(RANGE)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [IN_W-1:0]   I,
  input  logic              Req,
  input  logic              Ack,
`ifdef RNG_SEED_LOAD_EN
  input  logic              Load,
  input  logic [WIDTH-1:0]  SeedIn,
`endif
  output logic [OUT_W-1:0]  Value,
  output logic              Valid,
  output logic              Busy,
  output logic [7:0]        EntropyCount
);

  // A single-try build still needs a one-bit try counter.
  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [OUT_W:0]   RANGE_C  = RANGE[OUT_W:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [IN_W-1:0]    i_prev_q;
  logic [7:0]         ent_q, ent_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [OUT_W-1:0]   value_q, value_d;
  logic               valid_q, valid_d;

  logic               in_chg;
  logic [WIDTH-1:0]   stepped;
  logic [WIDTH-1:0]   mixed;
  logic [OUT_W-1:0]   cand;
  logic [OUT_W:0]     cand_ext;
  logic [OUT_W:0]     fb_diff;
  logic               cand_ok;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

  // Candidate is taken from the current register value, never the mixed one,
  // so entropy only influences later candidates.
  always_comb begin
    cand     = lfsr_q[OUT_W-1:0];
    cand_ext = {1'b0, cand};
    cand_ok  = (cand_ext < RANGE_C);
    fb_diff  = cand_ext - RANGE_C;
  end

  // Next LFSR value: step, optional entropy mix, zero-state recovery.
  always_comb begin
    in_chg  = (I != i_prev_q);
    stepped = lfsr_step(lfsr_q);
    mixed   = stepped;
    if (in_chg) begin
      mixed = stepped ^ WIDTH'(I);
    end
    lfsr_d = (mixed == '0) ? SEED : mixed;
`ifdef RNG_SEED_LOAD_EN
    if (Load) begin
      lfsr_d = (SeedIn == '0) ? SEED : SeedIn;
    end
`endif
    ent_d = in_chg ? (ent_q + 8'd1) : ent_q;
  end

  // LFSR, input history and entropy counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q   <= SEED;
      i_prev_q <= I;
      ent_q    <= 8'd0;
    end else begin
      lfsr_q   <= lfsr_d;
      i_prev_q <= I;
      ent_q    <= ent_d;
    end
  end

  // Draw FSM next-state and result logic.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    value_d = value_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (Req) begin
          state_d = S_DRAW;
          tries_d = '0;
        end
      end
      S_DRAW: begin
        if (cand_ok) begin
          value_d = cand;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else if (tries_q == LAST_TRY) begin
          // cand < 2*RANGE, so subtracting RANGE lands inside the range.
          value_d = fb_diff[OUT_W-1:0];
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      S_DONE: begin
        // A Req arriving together with Ack is dropped on purpose.
        if (Ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Draw FSM state and result registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      tries_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  // Busy is purely a decode of the registered state.
  always_comb begin
    Busy         = (state_q != S_IDLE);
    Value        = value_q;
    Valid        = valid_q;
    EntropyCount = ent_q;
  end

endmodule

// File: tb/tb_rng_draw.sv
// Directed bench for rng_draw. Three instances share all inputs:
//   u_a : defaults (RANGE=3, MAX_TRIES=4)
//   u_f : RANGE=3, MAX_TRIES=1 (exercises the fallback path)
//   u_5 : RANGE=5, MAX_TRIES=4
// Expected values come from hand-stepping the LFSR from SEED=16'hACE1:
//   s0..s12 = ACE1 E270 7138 389C 1C4E 0E27 B313 ED89 C2C4 6162 30B1 AC58 562C
// "edge k" below means the k-th rising edge after Reset is released.
module tb_rng_draw;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] I;
  logic       Req;
  logic       Ack;

  logic [1:0] val_a, val_f;
  logic [2:0] val_5;
  logic       valid_a, valid_f, valid_5;
  logic       busy_a, busy_f, busy_5;
  logic [7:0] ec_a, ec_f, ec_5;

  int n_assert = 0;
  int n_fail   = 0;

  int bins_a [3];
  int bins_5 [5];

  rng_draw u_a (
    .Clk(Clk), .Reset(Reset), .I(I), .Req(Req), .Ack(Ack),
    .Value(val_a), .Valid(valid_a), .Busy(busy_a), .EntropyCount(ec_a)
  );

  rng_draw #(.MAX_TRIES(1)) u_f (
    .Clk(Clk), .Reset(Reset), .I(I), .Req(Req), .Ack(Ack),
    .Value(val_f), .Valid(valid_f), .Busy(busy_f), .EntropyCount(ec_f)
  );

  rng_draw #(.RANGE(5)) u_5 (
    .Clk(Clk), .Reset(Reset), .I(I), .Req(Req), .Ack(Ack),
    .Value(val_5), .Valid(valid_5), .Busy(busy_5), .EntropyCount(ec_5)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Leaves Reset released 1ns after a rising edge; the next edge is edge 1.
  task automatic do_reset(input logic [1:0] iv);
    I     = iv;
    Req   = 1'b0;
    Ack   = 1'b0;
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int  budget;
    int  hold_n;
    logic [1:0] h_a, h_f;
    logic [2:0] h_5;

    // ---- reset values, constant input ----
    I = 2'b01; Req = 1'b0; Ack = 1'b0; Reset = 1'b1;
    tick(2);
    check("rst_value",  val_a, 0);
    check("rst_valid",  valid_a, 0);
    check("rst_busy",   busy_a, 0);
    check("rst_ec",     ec_a, 0);
    Reset = 1'b0;
    tick(20);
    check("ec_const_20", ec_a, 0);
    check("idle_busy_20", busy_a, 0);

    // ---- directed draws, I held at 01 ----
    do_reset(2'b01);
    tick(4);
    Req = 1'b1;
    tick();                                   // edge 5: IDLE -> DRAW
    Req = 1'b0;
    check("e5_busy_a",  busy_a, 1);
    check("e5_valid_a", valid_a, 0);
    tick();                                   // edge 6: cand s5=3
    check("e6_valid_f", valid_f, 1);
    check("e6_fallback_val_f", val_f, 0);
    check("e6_valid_a_retry", valid_a, 0);
    check("e6_busy_a",  busy_a, 1);
    check("e6_valid_5", valid_5, 0);
    tick();                                   // edge 7: cand s6 (3 / 3)
    check("e7_valid_5", valid_5, 1);
    check("e7_val_5",   val_5, 3);
    check("e7_valid_a", valid_a, 0);
    tick();                                   // edge 8: cand s7=1
    check("e8_valid_a", valid_a, 1);
    check("e8_val_a",   val_a, 1);
    check("e8_valid_f_held", valid_f, 1);
    Req = 1'b1;                               // ignored in DONE
    tick();
    check("e9_valid_a_held", valid_a, 1);
    check("e9_val_a_held",   val_a, 1);
    check("e9_val_5_held",   val_5, 3);
    Ack = 1'b1;                               // Req+Ack together: Req dropped
    tick();
    check("e10_valid_a", valid_a, 0);
    check("e10_busy_a",  busy_a, 0);
    check("e10_valid_f", valid_f, 0);
    check("e10_busy_5",  busy_5, 0);
    Req = 1'b0; Ack = 1'b0;
    tick();
    check("e11_no_queue_busy_a", busy_a, 0);
    check("e11_value_kept_a",    val_a, 1);
    Req = 1'b1;
    tick();                                   // edge 12: IDLE -> DRAW
    Req = 1'b0;
    check("e12_busy_a", busy_a, 1);
    tick();                                   // edge 13: cand s12=562C
    check("e13_valid_a", valid_a, 1);
    check("e13_val_a",   val_a, 0);
    check("e13_val_5",   val_5, 4);
    check("e13_val_f",   val_f, 0);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check("e14_valid_a", valid_a, 0);

    // ---- entropy mixing changes the first candidate ----
    do_reset(2'b00);
    I = 2'b01; Req = 1'b1;
    tick();                                   // edge 1: lfsr = E270 ^ 1 = E271
    Req = 1'b0;
    check("mix_ec1", ec_a, 1);
    tick();
    check("mix_valid_a", valid_a, 1);
    check("mix_val_a",   val_a, 1);
    check("mix_val_5",   val_5, 1);
    I = 2'b10;
    tick();
    check("mix_ec2", ec_a, 2);
    check("mix_val_a_held", val_a, 1);
    check("mix_valid_held", valid_a, 1);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;

    // ---- entropy counter and wrap ----
    do_reset(2'b00);
    I = 2'b01; tick();
    I = 2'b11; tick();
    check("ec_seq2", ec_a, 2);
    I = 2'b11; tick();
    I = 2'b00; tick();
    check("ec_seq3", ec_a, 3);
    for (int k = 0; k < 252; k++) begin
      I = I ^ 2'b01;
      tick();
    end
    check("ec_255", ec_a, 255);
    I = I ^ 2'b01;
    tick();
    check("ec_wrap0", ec_a, 0);

    // ---- reset mid-DRAW ----
    do_reset(2'b01);
    tick(4);
    Req = 1'b1;
    tick();
    Req = 1'b0;
    tick();                                   // edge 6: u_a in DRAW, u_f DONE
    check("mid_busy_a_pre",  busy_a, 1);
    check("mid_valid_f_pre", valid_f, 1);
    #2;
    Reset = 1'b1;
    #1;
    check("mid_valid_a", valid_a, 0);
    check("mid_busy_a",  busy_a, 0);
    check("mid_valid_f", valid_f, 0);
    check("mid_busy_f",  busy_f, 0);
    Reset = 1'b0;
    tick(3);
    check("mid_after_valid_a", valid_a, 0);
    check("mid_after_busy_a",  busy_a, 0);

    // ---- randomised draws with shared handshake ----
    foreach (bins_a[b]) bins_a[b] = 0;
    foreach (bins_5[b]) bins_5[b] = 0;
    for (int d = 0; d < 900; d++) begin
      I   = 2'($urandom_range(0, 3));
      Req = 1'b1;
      tick();
      Req = 1'b0;
      budget = 0;
      while (!(valid_a && valid_f && valid_5) && budget < 8) begin
        I = 2'($urandom_range(0, 3));
        tick();
        budget++;
      end
      check("rnd_all_valid", {valid_a, valid_f, valid_5}, 3'b111);
      check("rnd_range_a", (val_a < 2'd3), 1);
      check("rnd_range_f", (val_f < 2'd3), 1);
      check("rnd_range_5", (val_5 < 3'd5), 1);
      if (val_a < 2'd3) bins_a[val_a]++;
      if (val_5 < 3'd5) bins_5[val_5]++;
      h_a = val_a; h_f = val_f; h_5 = val_5;
      hold_n = $urandom_range(0, 3);
      for (int j = 0; j < hold_n; j++) begin
        I   = 2'($urandom_range(0, 3));
        Req = 1'($urandom_range(0, 1));
        tick();
        check("rnd_hold", {valid_a, valid_f, valid_5, val_a, val_f, val_5},
              {3'b111, h_a, h_f, h_5});
      end
      Req = 1'b0;
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      check("rnd_ack_clear", {valid_a, valid_f, valid_5, busy_a, busy_f, busy_5}, 6'b0);
    end
    for (int b = 0; b < 3; b++)
      check("bin_a_uniform", (bins_a[b] >= 210 && bins_a[b] <= 390), 1);
    for (int b = 0; b < 5; b++)
      check("bin_5_uniform", (bins_5[b] >= 120 && bins_5[b] <= 240), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
